// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor: Diff = (A - B - Bin) mod 2^WIDTH. DIGIT bits are
//   handled per clock through a registered borrow, so an operation takes
//   N = WIDTH/DIGIT RUN cycles. WIDTH must be a multiple of DIGIT.
//
//   Ports
//     clk     clock, rising edge
//     rst     asynchronous, active-high reset
//     start   request an operation (ignored while busy)
//     A, B    minuend / subtrahend, captured on the accepting edge
//     Bin     borrow-in, captured on the accepting edge
//     busy    high for the N RUN cycles
//     done    one-cycle pulse, Diff/Borrow valid
//     Diff    registered difference, updated only at completion
//     Borrow  registered borrow-out (A < B + Bin, unsigned)
//     Overflow (only with SERIAL_SUBTRACTOR_OVF_EN) signed overflow of the
//              result, registered alongside Diff
//
//   Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] part;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   digit_sub;
    logic [WIDTH-1:0] part_next;
    logic             last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // One digit stage: computed one bit wider, the top bit is the borrow out.
    assign digit_sub = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                     - {{DIGIT{1'b0}}, borrow};

    // New digit enters from the MSB side; after N steps the first digit has
    // walked down to bit 0. Written as a shift so DIGIT == WIDTH also works.
    assign part_next = WIDTH'({digit_sub[DIGIT-1:0], part} >> DIGIT);

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Borrow <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            part   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            Overflow <= 1'b0;
`endif
        end else begin
            case (state)
                // DONE behaves like IDLE for one cycle, which allows a
                // back-to-back start on the done edge.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        part   <= '0;
                        borrow <= Bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    part   <= part_next;
                    borrow <= digit_sub[DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        Diff   <= part_next;
                        Borrow <= digit_sub[DIGIT];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        Overflow <= (a_msb != b_msb) && (part_next[WIDTH-1] != a_msb);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Three instances: 8/1 (main, model-compared every cycle), 8/4 and 16/16
//   (per-operation arithmetic checks). Prints one summary line.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    logic       s1, bi1, busy1, done1, bo1;
    logic [7:0] a1, b1, diff1;
    logic       s4, bi4, busy4, done4, bo4;
    logic [7:0] a4, b4, diff4;
    logic        s16, bi16, busy16, done16, bo16;
    logic [15:0] a16, b16, diff16;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ov1, ov4, ov16;
`endif

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(s1), .A(a1), .B(b1), .Bin(bi1),
        .busy(busy1), .done(done1), .Diff(diff1), .Borrow(bo1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .Overflow(ov1)
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4), .Bin(bi4),
        .busy(busy4), .done(done4), .Diff(diff4), .Borrow(bo4)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .Overflow(ov4)
`endif
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(s16), .A(a16), .B(b16), .Bin(bi16),
        .busy(busy16), .done(done16), .Diff(diff16), .Borrow(bo16)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .Overflow(ov16)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Signed overflow from plain integer arithmetic.
    function automatic logic ovf8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int r;
        r = int'($signed(a)) - int'($signed(b)) - int'(bi);
        return (r > 127) || (r < -128);
    endfunction

    // Reference for the 8/1 instance: an accepted request produces its
    // arithmetic result exactly 8 cycles later; requests while busy are dropped.
    int         m_left;
    logic       m_busy, m_done, m_bo, p_bo, m_ov, p_ov;
    logic [7:0] m_diff, p_diff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;  m_busy <= 1'b0; m_done <= 1'b0;
            m_diff <= '0; m_bo   <= 1'b0; m_ov   <= 1'b0;
            p_diff <= '0; p_bo   <= 1'b0; p_ov   <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_diff <= p_diff;
                m_bo   <= p_bo;
                m_ov   <= p_ov;
            end
        end else begin
            m_done <= 1'b0;
            if (s1) begin
                m_busy <= 1'b1;
                m_left <= 8;
                p_diff <= a1 - b1 - {7'b0, bi1};
                p_bo   <= ({1'b0, a1} < ({1'b0, b1} + {8'b0, bi1}));
                p_ov   <= ovf8(a1, b1, bi1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_busy", busy1, m_busy);
            check("cmp_done", done1, m_done);
            check("cmp_diff", diff1, m_diff);
            check("cmp_borrow", bo1, m_bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check("cmp_ovf", ov1, m_ov);
`endif
        end
    end

    task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic bi);
        @(negedge clk); s1 = 1'b1; a1 = a; b1 = b; bi1 = bi;
        @(negedge clk); s1 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom); bi1 = 1'($urandom);
    endtask

    task automatic wait1(input string nm, input int exp_nb, input logic [7:0] ed, input logic eb);
        int nb = 0;
        int k  = 0;
        while (!done1 && k < 40) begin
            if (busy1) nb++;
            @(negedge clk);
            k++;
        end
        check({nm, "_done"}, done1, 1);
        check({nm, "_busy_cycles"}, nb, exp_nb);
        check({nm, "_diff"}, diff1, ed);
        check({nm, "_borrow"}, bo1, eb);
    endtask

    task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] full;
        int nb = 0;
        int k  = 0;
        full = {1'b0, a} - {1'b0, b} - {8'b0, bi};
        @(negedge clk); s4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
        @(negedge clk); s4 = 1'b0; a4 = ~a; b4 = ~b; bi4 = ~bi;
        while (!done4 && k < 20) begin
            if (busy4) nb++;
            @(negedge clk);
            k++;
        end
        check("d4_done", done4, 1);
        check("d4_busy_cycles", nb, 2);
        check("d4_diff", diff4, full[7:0]);
        check("d4_borrow", bo4, full[8]);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] full;
        int nb = 0;
        int k  = 0;
        full = {1'b0, a} - {1'b0, b} - {16'b0, bi};
        @(negedge clk); s16 = 1'b1; a16 = a; b16 = b; bi16 = bi;
        @(negedge clk); s16 = 1'b0; a16 = ~a; b16 = ~b; bi16 = ~bi;
        while (!done16 && k < 20) begin
            if (busy16) nb++;
            @(negedge clk);
            k++;
        end
        check("d16_done", done16, 1);
        check("d16_busy_cycles", nb, 1);
        check("d16_diff", diff16, full[15:0]);
        check("d16_borrow", bo16, full[16]);
    endtask

    initial begin
        int k;
        int seen;
        rst = 1'b1;
        s1 = 0;  a1 = 0;  b1 = 0;  bi1 = 0;
        s4 = 0;  a4 = 0;  b4 = 0;  bi4 = 0;
        s16 = 0; a16 = 0; b16 = 0; bi16 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_diff", diff1, 0);
        check("rst_borrow", bo1, 0);
        check("rst_d4_busy", busy4, 0);
        check("rst_d16_diff", diff16, 0);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // Basic operation
        start1(8'h5A, 8'h3C, 1'b0);
        wait1("t1", 8, 8'h1E, 1'b0);

        // Negative result, then result hold during the next RUN
        start1(8'h00, 8'h01, 1'b0);
        wait1("t2a", 8, 8'hFF, 1'b1);
        start1(8'h10, 8'h0F, 1'b1);
        repeat (3) @(negedge clk);
        check("t2_hold_diff", diff1, 8'hFF);
        check("t2_hold_borrow", bo1, 1);
        wait1("t2b", 5, 8'h00, 1'b0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        start1(8'h80, 8'h01, 1'b0);
        wait1("ovf_a", 8, 8'h7F, 1'b0);
        check("ovf_a_flag", ov1, 1);
        start1(8'h05, 8'h03, 1'b0);
        wait1("ovf_b", 8, 8'h02, 1'b0);
        check("ovf_b_flag", ov1, 0);
`endif

        // start while busy is ignored; start in DONE is accepted
        start1(8'h33, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        s1 = 1'b1; a1 = 8'hFF; b1 = 8'h00; bi1 = 1'b1;
        @(negedge clk); s1 = 1'b0;
        wait1("t3_ign", 5, 8'h22, 1'b0);
        s1 = 1'b1; a1 = 8'hC8; b1 = 8'h64; bi1 = 1'b0;
        @(negedge clk); s1 = 1'b0;
        k = 1;
        while (!done1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t3_b2b_spacing", k, 9);
        check("t3_b2b_diff", diff1, 8'h64);
        check("t3_b2b_borrow", bo1, 0);

        // Reset in the middle of RUN
        start1(8'h77, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_busy", busy1, 0);
        check("t4_rst_done", done1, 0);
        check("t4_rst_diff", diff1, 0);
        check("t4_rst_borrow", bo1, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done1) seen++;
        end
        check("t4_no_done", seen, 0);
        start1(8'h9C, 8'hA7, 1'b1);
        wait1("t4_after", 8, 8'hF4, 1'b1);

        // DIGIT=4 and single-cycle instance
        op4(8'hF0, 8'h0F, 1'b0);
        check("d4_lit_diff", diff4, 8'hE1);
        for (int i = 0; i < 10; i++) op4(8'($urandom), 8'($urandom), 1'($urandom));
        op16(16'h0000, 16'h0001, 1'b1);
        check("d16_lit_diff", diff16, 16'hFFFE);
        for (int i = 0; i < 30; i++) op16(16'($urandom), 16'($urandom), 1'($urandom));

        // Random traffic on the main instance, checked cycle by cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            s1  = ($urandom_range(3) == 0);
            a1  = 8'($urandom);
            b1  = 8'($urandom);
            bi1 = 1'($urandom);
        end
        s1 = 1'b0;
        repeat (12) @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor that computes Diff = A - B - Bin over WIDTH bits. It processes DIGIT bits per clock with a registered borrow chain, so each cycle is one chained half/full-subtractor stage. It uses a start/busy/done handshake and is intended for area-constrained datapaths where a full-width combinational subtractor is not wanted.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
DIGIT, 1, bits processed per cycle; WIDTH % DIGIT == 0 is required; N = WIDTH/DIGIT is the cycle count

Ports:
clk     input   1      clock; all state updates on rising edge
rst     input   1      asynchronous, active-high reset
start   input   1      request a new operation; sampled only when not busy
A       input   WIDTH  minuend; sampled on the accepting edge only
B       input   WIDTH  subtrahend; sampled on the accepting edge only
Bin     input   1      borrow-in; sampled on the accepting edge only
busy    output  1      high while the operation is in progress
done    output  1      single-cycle pulse when the result is valid
Diff    output  WIDTH  registered result (A - B - Bin) mod 2^WIDTH
Borrow  output  1      registered final borrow-out (1 when A < B + Bin, unsigned)

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, Diff=0, Borrow=0; shift registers, borrow FF and digit counter all cleared. Reset during RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, latch A, B into shift regs and Bin into the borrow FF, clear the counter, go to RUN, busy=1. Otherwise remain.
- RUN: each edge takes the low DIGIT bits of each shift reg plus the borrow FF and computes a DIGIT-bit difference and a new borrow. The difference digit shifts into the partial-result reg from the MSB side. The operand regs shift right by DIGIT and the counter increments. After the Nth RUN edge: copy the partial result to Diff, copy the borrow to Borrow, busy=0, done=1, go to DONE.
- Latency: start accepted at edge k means done=1 and a valid Diff/Borrow in the cycle after edge k+N. busy is high for exactly N cycles.
- DONE: lasts one cycle and done=1. If start=1 at this edge, the next operation is accepted (back-to-back, go to RUN, done drops). Otherwise go to IDLE, done=0.
- start while busy=1 is ignored; it is not queued.
- Diff and Borrow change only at completion. They hold the previous result through later RUN cycles and until the next completion.
- Input changes on A, B or Bin after the accepting edge have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. With DIGIT=WIDTH, N=1: the result appears one cycle after acceptance.

Optional Feature:
Macro SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output Overflow (1 bit). It is registered together with Diff and is the two's-complement signed overflow: (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]), computed from the latched operands and including Bin. It resets to 0 and holds like Diff.
- Undefined: no Overflow port, and no extra logic or state.

Test Plan:
- WIDTH=8, DIGIT=1; A=0x5A, B=0x3C, Bin=0, pulse start -> busy high 8 cycles, done pulse, Diff=0x1E, Borrow=0.
- A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Borrow=1. Then A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Borrow=0. Diff=0xFF holds during the second operation's RUN.
- Assert start again at cycle 3 of RUN with different operands -> ignored, result matches the first operands. Then start during the DONE cycle -> accepted back-to-back, done pulses exactly N+1 cycles apart.
- Assert rst at RUN cycle 4 -> busy=0, done never pulses, Diff=0, Borrow=0. A new start afterwards gives a correct result.
- WIDTH=8, DIGIT=4; A=0xF0, B=0x0F -> busy for 2 cycles, Diff=0xE1, Borrow=0. WIDTH=16, DIGIT=16 -> 1-cycle latency; exhaustive random compare against A-B-Bin.
- With SERIAL_SUBTRACTOR_OVF_EN, WIDTH=8: A=0x80, B=0x01 -> Diff=0x7F, Overflow=1. A=0x05, B=0x03 -> Overflow=0.
